// File: rtl/spo2_pkg.sv
// Shared types and constants for the SpO2 ratio path.
package spo2_pkg;

    localparam int unsigned ADC_W = 8;
    localparam int unsigned NUM_W = 24;
    localparam int unsigned DEN_W = 16;

    localparam logic [ADC_W-1:0] MIN_INIT  = 8'd255;
    localparam logic [ADC_W-1:0] MAX_INIT  = 8'd0;
    localparam logic [15:0]      RATIO_SAT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        MULT,
        DIVIDE,
        DONE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// 24b/16b restoring divider, one quotient bit per cycle, fixed 24-cycle latency.
module seq_divider
    import spo2_pkg::*;
(
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             done,
    output logic [NUM_W-1:0] quotient,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d, den_q;
    logic [DEN_W:0]   rem_sh;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;

    always_comb begin
        rem_sh = {rem_q, quo_q[NUM_W-1]};
        if (rem_sh >= {1'b0, den_q}) begin
            rem_d = DEN_W'(rem_sh - {1'b0, den_q});
            quo_d = {quo_q[NUM_W-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[DEN_W-1:0];
            quo_d = {quo_q[NUM_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            den_q <= divisor;
            cnt_q <= CNT_W'(NUM_W);
            dbz_q <= (divisor == '0);
        end else if (cnt_q != '0) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // The last step is presented combinationally so the caller registers it on the same edge.
    assign done        = (cnt_q == CNT_W'(1));
    assign quotient    = quo_d;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/spo2_ratio_evaluator.sv
// Captures RED/IR samples per LED phase, tracks min/max per window and
// produces the Q8.8 ratio-of-ratios R with a one-cycle valid pulse.
module spo2_ratio_evaluator
    import spo2_pkg::*;
#(
    parameter int unsigned WIN_LEN   = 1000,
    parameter int unsigned FRAC_BITS = 8
)(
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] RED_ADC_Value,
    input  logic [ADC_W-1:0] IR_ADC_Value,
    input  logic             LED_RED,
    input  logic             LED_IR,
    input  logic             Setting_Done,
    output logic [15:0]      Ratio_R,
    output logic             Ratio_Valid,
    output logic             Sat_Err,
    output logic             Busy
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

    state_t           state_q, state_d;
    logic             led_red_q, led_ir_q;
    logic             red_cap, ir_cap;
    logic [ADC_W-1:0] red_min, red_max, ir_min, ir_max;
    logic [CNT_W-1:0] pair_cnt;
    logic             red_seen;
    logic             clear_acc, div_start, load_result;
    logic [ADC_W-1:0] ac_red, ac_ir, dc_red, dc_ir;
    logic [DEN_W-1:0] prod_num, den;
    logic [NUM_W-1:0] num, div_q;
    logic             div_done, div_dbz;

    // A fall only counts when the other LED was dark in the previous cycle.
    assign red_cap = led_red_q & ~LED_RED & ~led_ir_q;
    assign ir_cap  = led_ir_q  & ~LED_IR  & ~led_red_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            led_red_q <= 1'b0;
            led_ir_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_red_q <= LED_RED;
            led_ir_q  <= LED_IR;
        end
    end

    always_comb begin
        state_d     = state_q;
        Busy        = 1'b0;
        clear_acc   = 1'b0;
        div_start   = 1'b0;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                clear_acc = 1'b1;
                state_d   = ACCUM;
            end
            ACCUM: begin
                if (ir_cap && red_seen && pair_cnt == CNT_W'(WIN_LEN - 1))
                    state_d = MULT;
            end
            MULT: begin
                Busy      = 1'b1;
                div_start = 1'b1;
                state_d   = DIVIDE;
            end
            DIVIDE: begin
                Busy = 1'b1;
                if (div_done) begin
                    load_result = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                Busy      = 1'b1;
                clear_acc = 1'b1;
                state_d   = ACCUM;
            end
            default: state_d = IDLE;
        endcase
        if (!Setting_Done) begin
            state_d     = IDLE;
            clear_acc   = 1'b1;
            div_start   = 1'b0;
            load_result = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            red_min  <= MIN_INIT;
            red_max  <= MAX_INIT;
            ir_min   <= MIN_INIT;
            ir_max   <= MAX_INIT;
            pair_cnt <= '0;
            red_seen <= 1'b0;
        end else if (clear_acc) begin
            red_min  <= MIN_INIT;
            red_max  <= MAX_INIT;
            ir_min   <= MIN_INIT;
            ir_max   <= MAX_INIT;
            pair_cnt <= '0;
            red_seen <= 1'b0;
        end else if (state_q == ACCUM) begin
            if (red_cap) begin
                if (RED_ADC_Value < red_min) red_min <= RED_ADC_Value;
                if (RED_ADC_Value > red_max) red_max <= RED_ADC_Value;
                red_seen <= 1'b1;
            end
            if (ir_cap) begin
                if (IR_ADC_Value < ir_min) ir_min <= IR_ADC_Value;
                if (IR_ADC_Value > ir_max) ir_max <= IR_ADC_Value;
                if (red_seen) begin
                    pair_cnt <= pair_cnt + CNT_W'(1);
                    red_seen <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        ac_red   = red_max - red_min;
        ac_ir    = ir_max - ir_min;
        dc_red   = ADC_W'(({1'b0, red_max} + {1'b0, red_min}) >> 1);
        dc_ir    = ADC_W'(({1'b0, ir_max} + {1'b0, ir_min}) >> 1);
        prod_num = DEN_W'(ac_red) * DEN_W'(dc_ir);
        num      = NUM_W'(prod_num) << FRAC_BITS;
        den      = DEN_W'(ac_ir) * DEN_W'(dc_red);
    end

    seq_divider u_div (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .start       (div_start),
        .dividend    (num),
        .divisor     (den),
        .done        (div_done),
        .quotient    (div_q),
        .div_by_zero (div_dbz)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Ratio_R     <= '0;
            Ratio_Valid <= 1'b0;
            Sat_Err     <= 1'b0;
        end else begin
            Ratio_Valid <= load_result;
            if (load_result) begin
                if (div_dbz || div_q[NUM_W-1:16] != '0) begin
                    Ratio_R <= RATIO_SAT;
                    Sat_Err <= 1'b1;
                end else begin
                    Ratio_R <= div_q[15:0];
                    Sat_Err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spo2_ratio_evaluator.sv
// Self-checking bench for spo2_ratio_evaluator with WIN_LEN=4.
module tb_spo2_ratio_evaluator;

    localparam int unsigned WIN = 4;

    typedef int unsigned quad_t [4];
    typedef struct {
        int unsigned ra, rb, ia, ib;
        logic [15:0] exp_r;
        logic        exp_s;
    } vec_t;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [7:0]  RED_ADC_Value, IR_ADC_Value;
    logic        LED_RED, LED_IR, Setting_Done;
    logic [15:0] Ratio_R;
    logic        Ratio_Valid, Sat_Err, Busy;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [15:0] last_r;
    logic        last_s;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    spo2_ratio_evaluator #(.WIN_LEN(WIN), .FRAC_BITS(8)) dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .LED_RED       (LED_RED),
        .LED_IR        (LED_IR),
        .Setting_Done  (Setting_Done),
        .Ratio_R       (Ratio_R),
        .Ratio_Valid   (Ratio_Valid),
        .Sat_Err       (Sat_Err),
        .Busy          (Busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic no_valid_for(input int unsigned n, input string nm);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (Ratio_Valid) seen = 1'b1;
            tick();
        end
        chk(nm, seen, 0);
    endtask

    // ADC lines carry noise except in the exact cycle of the LED fall.
    task automatic do_pair(input int unsigned r, input int unsigned i, output int unsigned t_ir);
        RED_ADC_Value = 8'($urandom);
        LED_RED = 1'b1;
        tick(); tick(); tick();
        RED_ADC_Value = 8'(r);
        LED_RED = 1'b0;
        tick();
        RED_ADC_Value = 8'($urandom);
        IR_ADC_Value  = 8'($urandom);
        LED_IR = 1'b1;
        tick(); tick(); tick();
        IR_ADC_Value = 8'(i);
        LED_IR = 1'b0;
        t_ir = cyc;
        tick();
        IR_ADC_Value = 8'($urandom);
    endtask

    task automatic both_high();
        RED_ADC_Value = 8'd0;
        IR_ADC_Value  = 8'd255;
        LED_RED = 1'b1;
        LED_IR  = 1'b1;
        tick(); tick(); tick();
        LED_RED = 1'b0;
        LED_IR  = 1'b0;
        tick(); tick();
    endtask

    function automatic void ref_ratio(input quad_t r, input quad_t i,
                                      output logic [15:0] er, output logic es);
        int unsigned rmin, rmax, imin, imax;
        longint unsigned num, den, q;
        rmin = 255; rmax = 0; imin = 255; imax = 0;
        for (int p = 0; p < 4; p++) begin
            if (r[p] < rmin) rmin = r[p];
            if (r[p] > rmax) rmax = r[p];
            if (i[p] < imin) imin = i[p];
            if (i[p] > imax) imax = i[p];
        end
        num = longint'(rmax - rmin) * ((imax + imin) / 2) * 256;
        den = longint'(imax - imin) * ((rmax + rmin) / 2);
        er = 16'hFFFF;
        es = 1'b1;
        if (den != 0) begin
            q = num / den;
            if (q <= 65535) begin
                er = 16'(q);
                es = 1'b0;
            end
        end
    endfunction

    // mode 0: plain window; 1: also confirm silence after 3 pairs; 2: as 1 with a both-LED fall injected.
    task automatic run_window(input quad_t r, input quad_t i, input logic [15:0] er,
                              input logic es, input int unsigned mode, input string nm);
        int unsigned t, vcyc;
        logic found;
        t = 0;
        for (int p = 0; p < 4; p++) begin
            do_pair(r[p], i[p], t);
            if (mode == 2 && p == 0) both_high();
            if (mode != 0 && p == 2) no_valid_for(40, {nm, "_early"});
        end
        chk({nm, "_busy_mult"}, Busy, 1);
        found = 1'b0;
        vcyc  = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (Ratio_Valid) begin
                found = 1'b1;
                vcyc  = cyc;
            end else begin
                tick();
            end
        end
        chk({nm, "_valid_cycle"}, found ? vcyc - t : 0, 26);
        chk({nm, "_ratio"}, Ratio_R, er);
        chk({nm, "_sat"}, Sat_Err, es);
        chk({nm, "_busy_done"}, Busy, 1);
        tick();
        chk({nm, "_valid_pulse"}, Ratio_Valid, 0);
        chk({nm, "_busy_clear"}, Busy, 0);
        last_r = er;
        last_s = es;
    endtask

    function automatic void alt(input int unsigned a, input int unsigned b, output quad_t q);
        for (int p = 0; p < 4; p++) q[p] = (p % 2 == 0) ? a : b;
    endfunction

    initial begin
        vec_t tbl [7];
        quad_t r, i;
        logic [15:0] er;
        logic es;
        int unsigned t;

        tbl[0] = '{100, 140,  80, 160, 16'h0080, 1'b0};
        tbl[1] = '{200, 200, 100, 100, 16'hFFFF, 1'b1};
        tbl[2] = '{100, 140,  80, 160, 16'h0080, 1'b0};
        tbl[3] = '{ 50, 150, 100, 200, 16'h0180, 1'b0};
        tbl[4] = '{ 10,  30,  60, 100, 16'h0200, 1'b0};
        tbl[5] = '{  0,   3,   0,   7, 16'h0149, 1'b0};
        tbl[6] = '{  0, 255, 254, 255, 16'hFFFF, 1'b1};

        rst_n = 1'b0;
        Setting_Done = 1'b0;
        LED_RED = 1'b0;
        LED_IR  = 1'b0;
        RED_ADC_Value = '0;
        IR_ADC_Value  = '0;
        last_r = '0;
        last_s = 1'b0;
        tick(); tick();
        chk("reset_ratio", Ratio_R, 0);
        chk("reset_valid", Ratio_Valid, 0);
        chk("reset_sat", Sat_Err, 0);
        chk("reset_busy", Busy, 0);
        rst_n = 1'b1;
        Setting_Done = 1'b1;
        tick(); tick();

        for (int n = 0; n < 7; n++) begin
            alt(tbl[n].ra, tbl[n].rb, r);
            alt(tbl[n].ia, tbl[n].ib, i);
            run_window(r, i, tbl[n].exp_r, tbl[n].exp_s, 0, $sformatf("vec%0d", n));
        end

        // Abort mid-divide: result must not appear and the previous result stays.
        alt(50, 150, r);
        alt(100, 200, i);
        for (int p = 0; p < 4; p++) do_pair(r[p], i[p], t);
        for (int k = 0; k < 9; k++) tick();
        Setting_Done = 1'b0;
        tick();
        chk("abort_idle", Busy, 0);
        chk("abort_hold_ratio", Ratio_R, last_r);
        chk("abort_hold_sat", Sat_Err, last_s);
        Setting_Done = 1'b1;
        no_valid_for(40, "abort_no_valid");
        run_window(r, i, 16'h0180, 1'b0, 1, "abort_refill");

        alt(100, 140, r);
        alt(80, 160, i);
        run_window(r, i, 16'h0080, 1'b0, 2, "both_high");

        for (int w = 0; w < 6; w++) begin
            for (int p = 0; p < 4; p++) begin
                r[p] = $urandom_range(0, 255);
                i[p] = $urandom_range(0, 255);
            end
            ref_ratio(r, i, er, es);
            run_window(r, i, er, es, 0, $sformatf("rand%0d", w));
        end

        alt(0, 255, r);
        alt(254, 255, i);
        run_window(r, i, 16'hFFFF, 1'b1, 0, "sat_before_reset");

        // Asynchronous reset in the middle of a divide.
        alt(100, 140, r);
        alt(80, 160, i);
        for (int p = 0; p < 4; p++) do_pair(r[p], i[p], t);
        for (int k = 0; k < 9; k++) tick();
        chk("pre_reset_busy", Busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ratio", Ratio_R, 0);
        chk("async_busy", Busy, 0);
        chk("async_sat", Sat_Err, 0);
        chk("async_valid", Ratio_Valid, 0);
        #3 rst_n = 1'b1;
        tick();
        run_window(r, i, 16'h0080, 1'b0, 1, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
